// File: rtl/conv_layer_pkg.sv
// rtl/conv_layer_pkg.sv - shared encodings and defaults for the conv-layer buffer initiator
package conv_layer_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_INPUT_SIZE = 8;
  localparam logic [31:0] FLOAT32_ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {
    BUFFER_CMD_IDLE = 2'd0,
    BUFFER_CMD_LOAD = 2'd1,
    BUFFER_CMD_READ = 2'd2
  } buffer_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ACK,
    S_READ,
    S_DONE
  } state_e;
endpackage

// File: rtl/conv_layer_row_fetcher.sv
// rtl/conv_layer_row_fetcher.sv - reads one image row from memory and replays it as LOAD beats
module conv_layer_row_fetcher
  import conv_layer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int ADDR_WIDTH = 6,
  parameter int ROW_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_row,
  input  logic [ROW_W-1:0]      row,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  load,
  output logic                  row_done
);
  localparam int COL_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  logic             active;
  logic             load_q;
  logic             last_q;
  logic [COL_W-1:0] col;
  logic             col_last;

  assign col_last = (col == COL_W'(INPUT_SIZE - 1));

  // Each read beat is captured at the edge closing its cycle, so LOAD trails mem_rd_en by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      col      <= '0;
      load_q   <= 1'b0;
      last_q   <= 1'b0;
      data_out <= '0;
    end else begin
      load_q <= active;
      last_q <= active && col_last;
      if (active) begin
        data_out <= mem_data;
      end
      if (start_row) begin
        active <= 1'b1;
        col    <= '0;
      end else if (active) begin
        if (col_last) begin
          active <= 1'b0;
          col    <= '0;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign mem_rd_en = active;
  assign mem_addr  = active ? (ADDR_WIDTH'(row) * ADDR_WIDTH'(INPUT_SIZE) + ADDR_WIDTH'(col)) : '0;
  assign load      = load_q;
  assign row_done  = load_q && last_q;
endmodule

// File: rtl/conv_layer_buffer_ctrl.sv
// rtl/conv_layer_buffer_ctrl.sv - sequences row LOADs and 3-row window READs into the conv input buffer
module conv_layer_buffer_ctrl
  import conv_layer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int INPUT_SIZE   = DEF_INPUT_SIZE,
  parameter int IMAGE_ROWS   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int SHIFT_CYCLES = 6,
  parameter int ACK_TIMEOUT  = 15,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  compute_ready,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            buffer_cmd,
  output logic [1:0]            buffer_array_idx,
  input  logic                  buffer_ack,
  output logic                  row_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);
  localparam int ROW_W   = $clog2(IMAGE_ROWS + 1);
  localparam int SHIFT_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam int PRE_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

  state_e             state, state_d;
  logic [ROW_W-1:0]   row_cnt;
  logic [PRE_W-1:0]   preload_cnt;
  logic [TIMER_W-1:0] timer;
  logic [SHIFT_W-1:0] shift_cnt;
  logic [1:0]         idx;
  logic               start_row;
  logic               load;
  logic               row_done;
  logic               preload_more;
  logic               ack_expired;
  logic               shift_last;
  logic               idx_last;
  logic               window_end;
  logic               more_rows;

  conv_layer_row_fetcher #(
    .DATA_WIDTH (DATA_WIDTH),
    .INPUT_SIZE (INPUT_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROW_W      (ROW_W)
  ) u_fetcher (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_row (start_row),
    .row       (row_cnt),
    .mem_data  (mem_data),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .data_out  (data_out),
    .load      (load),
    .row_done  (row_done)
  );

  assign preload_more = (preload_cnt < PRE_W'(KERNEL_SIZE - 1));
  // timer counts WAIT_ACK cycles from 1, so err_timeout lands ACK_TIMEOUT cycles after the final LOAD.
  assign ack_expired  = (timer == TIMER_W'(ACK_TIMEOUT - 1));
  assign shift_last   = (shift_cnt == SHIFT_W'(SHIFT_CYCLES - 1));
  assign idx_last     = (idx == 2'(KERNEL_SIZE - 1));
  assign window_end   = (state == S_READ) && compute_ready && shift_last && idx_last;
  assign more_rows    = (row_cnt < ROW_W'(IMAGE_ROWS));

  always_comb begin
    state_d   = state;
    start_row = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          start_row = 1'b1;
        end
      end
      S_FETCH: begin
        if (row_done) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (buffer_ack) begin
          if (preload_more) begin
            state_d   = S_FETCH;
            start_row = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end else if (ack_expired) begin
          state_d = S_DONE;
        end
      end
      S_READ: begin
        if (window_end) begin
          if (more_rows) begin
            state_d   = S_FETCH;
            start_row = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      row_cnt     <= '0;
      preload_cnt <= '0;
      timer       <= '0;
      shift_cnt   <= '0;
      idx         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            row_cnt     <= '0;
            preload_cnt <= '0;
            err_timeout <= 1'b0;
          end
        end
        S_FETCH: timer <= TIMER_W'(1);
        S_WAIT_ACK: begin
          if (buffer_ack) begin
            row_cnt <= row_cnt + 1'b1;
            if (preload_more) preload_cnt <= preload_cnt + 1'b1;
          end else if (ack_expired) begin
            err_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_READ: begin
          if (compute_ready) begin
            if (shift_last) begin
              shift_cnt <= '0;
              idx       <= idx_last ? 2'd0 : idx + 2'd1;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign buffer_cmd       = load ? BUFFER_CMD_LOAD :
                            (state == S_READ) ? BUFFER_CMD_READ : BUFFER_CMD_IDLE;
  assign buffer_array_idx = (state == S_READ) ? idx : 2'd0;
  assign row_last         = window_end;
  assign busy             = (state == S_FETCH) || (state == S_WAIT_ACK) || (state == S_READ);
  assign done             = (state == S_DONE);
endmodule

// File: tb/tb_conv_layer_buffer_ctrl.sv
// tb/tb_conv_layer_buffer_ctrl.sv - scoreboard bench for conv_layer_buffer_ctrl
module tb_conv_layer_buffer_ctrl;
  localparam int DW = 32, IS = 8, IR = 8, KS = 3, SC = 6, AT = 15, AW = 6;
  localparam int OUT_ROWS = IR - KS + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          compute_ready = 1'b1;
  logic          buffer_ack = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] data_out;
  logic [1:0]    buffer_cmd;
  logic [1:0]    buffer_array_idx;
  logic          row_last, busy, done, err_timeout;

  logic [DW-1:0] mem [IS*IR];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  conv_layer_buffer_ctrl #(
    .DATA_WIDTH(DW), .INPUT_SIZE(IS), .IMAGE_ROWS(IR), .KERNEL_SIZE(KS),
    .SHIFT_CYCLES(SC), .ACK_TIMEOUT(AT), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .compute_ready(compute_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .data_out(data_out), .buffer_cmd(buffer_cmd), .buffer_array_idx(buffer_array_idx),
    .buffer_ack(buffer_ack), .row_last(row_last), .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard expectations
  int            exp_addr[$];
  logic [DW-1:0] exp_load[$];
  int            exp_idx[$];
  bit            exp_last[$];
  bit            exp_err = 1'b0;

  // Reference: every row is loaded in order; once KS rows are present each new row yields one window pass.
  task automatic build_expect(input bit no_ack);
    exp_addr.delete(); exp_load.delete(); exp_idx.delete(); exp_last.delete();
    for (int r = 0; r < IR; r++) begin
      for (int c = 0; c < IS; c++) begin
        exp_addr.push_back(r * IS + c);
        exp_load.push_back(mem[r * IS + c]);
      end
      if (no_ack) break;
      if (r >= KS - 1) begin
        for (int k = 0; k < KS * SC; k++) begin
          exp_idx.push_back(k / SC);
          exp_last.push_back(k == KS * SC - 1);
        end
      end
    end
  endtask

  // Monitor
  int cyc = 0;
  int last_load_cyc = 0;
  int read_cycles = 0;
  int done_cnt = 0;
  int row_reads[$];

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) check("extra_mem_read", 1, 0);
        else check("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (buffer_cmd == 2'd1) begin
        last_load_cyc = cyc;
        if (exp_load.size() == 0) check("extra_load", 1, 0);
        else check("data_out", data_out, exp_load.pop_front());
      end else if (buffer_cmd == 2'd2) begin
        read_cycles++;
        if (exp_idx.size() == 0) check("extra_read_cmd", 1, 0);
        else begin
          check("array_idx", buffer_array_idx, exp_idx[0]);
          check("row_last", row_last, exp_last[0] && compute_ready);
          if (compute_ready) begin
            void'(exp_idx.pop_front());
            void'(exp_last.pop_front());
          end
        end
        if (row_last) begin
          row_reads.push_back(read_cycles);
          read_cycles = 0;
        end
      end else begin
        check("cmd_idle", buffer_cmd, 0);
        check("row_last_idle", row_last, 0);
      end
      if (done) begin
        done_cnt++;
        check("err_timeout_at_done", err_timeout, exp_err);
        check("busy_at_done", busy, 0);
        check("leftover_expect", exp_addr.size() + exp_load.size() + exp_idx.size(), 0);
        if (exp_err) check("timeout_latency", cyc - last_load_cyc, AT);
      end
    end
  end

  // Buffer / datapath model: ack mode 0=ack after burst, 1=plus spurious acks, 2=never ack
  int ack_mode = 0;
  int cr_mode = 1;
  int burst = 0;
  int idx1_seen = 0;
  int stall_left = 0;
  bit stalled = 1'b0;

  always begin
    logic nack, ncr;
    @(negedge clk);
    nack = 1'b0;
    if (!rst_n) burst = 0;
    else if (buffer_cmd == 2'd1) begin
      burst++;
      if (burst == IS) begin
        burst = 0;
        nack = (ack_mode != 2);
      end else if (ack_mode == 1) nack = ($urandom_range(0, 2) == 0);
    end else if (buffer_cmd == 2'd2 && ack_mode == 1) nack = ($urandom_range(0, 2) == 0);
    if (cr_mode == 3) begin
      if (rst_n && buffer_cmd == 2'd2 && buffer_array_idx == 2'd1 && compute_ready && !stalled) begin
        idx1_seen++;
        if (idx1_seen == 3) begin
          stalled = 1'b1;
          stall_left = 5;
        end
      end
      if (stall_left > 0) begin
        ncr = 1'b0;
        stall_left--;
      end else ncr = 1'b1;
    end else if (cr_mode == 2) ncr = ($urandom_range(0, 3) != 0);
    else ncr = 1'b1;
    @(posedge clk);
    #1;
    buffer_ack = nack;
    compute_ready = ncr;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_map(input int am, input int cm, input bit restart);
    bit got, pulsed;
    ack_mode = am; cr_mode = cm;
    stalled = 1'b0; idx1_seen = 0; stall_left = 0;
    exp_err = (am == 2);
    build_expect(am == 2);
    row_reads.delete(); read_cycles = 0; done_cnt = 0;
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("err_cleared_by_start", err_timeout, 0);
    got = 1'b0; pulsed = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (restart && !pulsed && buffer_cmd == 2'd2) begin
        pulsed = 1'b1;
        pulse_start();
      end
    end
    check("done_seen", got, 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("output_rows", row_reads.size(), (am == 2) ? 0 : OUT_ROWS);
    if (cm == 1) foreach (row_reads[i]) check("row_read_cycles", row_reads[i], KS * SC);
    if (cm == 3 && row_reads.size() > 0) check("stalled_row_cycles", row_reads[0], KS * SC + 5);
  endtask

  initial begin
    int loads;
    for (int i = 0; i < IS * IR; i++) mem[i] = i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {mem_rd_en, mem_addr, data_out, buffer_array_idx, row_last, busy, done, err_timeout}, 0);
    check("reset_cmd", buffer_cmd, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_map(0, 1, 1'b0);
    run_map(0, 3, 1'b0);
    run_map(2, 1, 1'b0);
    for (int i = 0; i < IS * IR; i++) mem[i] = $urandom();
    run_map(1, 2, 1'b1);

    ack_mode = 0; cr_mode = 1; exp_err = 1'b0;
    build_expect(1'b0);
    pulse_start();
    loads = 0;
    for (int n = 0; n < 200 && loads < 4; n++) begin
      @(negedge clk);
      if (buffer_cmd == 2'd1) loads++;
    end
    check("reached_fourth_load", loads, 4);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {mem_rd_en, mem_addr, data_out, buffer_array_idx, row_last, busy, done, err_timeout}, 0);
    check("async_reset_cmd", buffer_cmd, 0);
    exp_addr.delete(); exp_load.delete(); exp_idx.delete(); exp_last.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < IS * IR; i++) mem[i] = $urandom();
    run_map(1, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
